// File: rtl/vga_frame_scheduler.sv
// VGA 640x480@60 raster timing generator with a once-per-frame vblank update handshake.
// Latency: sync/blank/coordinate decodes are combinational from the registered counters;
//          handshake outputs are registered and follow the FSM with one clock of latency.
// Backpressure: none; the raster free-runs and upd_done is only sampled while the window is open.
//
// Ports:
//   clk25MHz     in   pixel clock
//   rst_n        in   synchronous active-low reset
//   upd_done     in   render logic finished its vblank update (level)
//   hsync/vsync  out  active-low sync pulses
//   video_on     out  inside the visible region
//   pixel_x/y    out  current column / line
//   frame_start  out  high at (0,0)
//   upd_req      out  update window open
//   buf_swap     out  one-cycle strobe, update accepted
//   frame_miss   out  one-cycle strobe, window closed without upd_done
//   frame_count  out  completed-frame counter (wraps at 2^16)
//   missed_frames out saturating miss counter, only when VGA_MISS_STATS_EN is defined
//
// Optional feature macro: VGA_MISS_STATS_EN

module vga_frame_scheduler #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int GUARD_LINES = 2
) (
  input  logic        clk25MHz,
  input  logic        rst_n,
  input  logic        upd_done,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        upd_req,
  output logic        buf_swap,
  output logic        frame_miss,
  output logic [15:0] frame_count
`ifdef VGA_MISS_STATS_EN
  ,
  output logic [7:0]  missed_frames
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Window opens after the last visible line has fully scanned out.
  localparam logic [9:0] V_OPEN     = 10'(V_ACTIVE - 1);
  // Last line on which a pending update may still be accepted; the guard
  // lines after it give the renderer slack before active video restarts.
  localparam logic [9:0] V_DEADLINE = 10'(V_TOTAL - 1 - GUARD_LINES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SWAP,
    ST_MISS,
    ST_WAIT
  } state_t;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       frame_end;

  state_t     state_q;
  state_t     state_d;

  assign h_wrap    = (h_cnt == H_MAX);
  assign frame_end = h_wrap && (v_cnt == V_MAX);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_cnt == V_MAX) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end

      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Zero-latency decodes from the registered counters
  // ---------------------------------------------------------------------------
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign hsync       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vsync       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // ---------------------------------------------------------------------------
  // Update-window handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (h_wrap && (v_cnt == V_OPEN)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // done is checked first so that a done on the deadline cycle still swaps
        if (upd_done) begin
          state_d = ST_SWAP;
        end else if (h_wrap && (v_cnt == V_DEADLINE)) begin
          state_d = ST_MISS;
        end
      end
      ST_SWAP: state_d = ST_WAIT;
      ST_MISS: state_d = ST_WAIT;
      ST_WAIT: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered straight from the next state, so they line up
  // with the state register and carry no decode glitches.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      upd_req    <= 1'b0;
      buf_swap   <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      state_q    <= state_d;
      upd_req    <= (state_d == ST_REQ);
      buf_swap   <= (state_d == ST_SWAP);
      frame_miss <= (state_d == ST_MISS);
    end
  end

`ifdef VGA_MISS_STATS_EN
  // Saturating count of missed windows; only reset clears it.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      missed_frames <= '0;
    end else if (frame_miss && (missed_frames != 8'hFF)) begin
      missed_frames <= missed_frames + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
module tb_vga_frame_scheduler;

  // Reduced raster so many frames fit in a short run.
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 12, VFP = 3, VS = 2, VBP = 5;
  localparam int G  = 2;
  localparam int HT = HA + HFP + HS + HBP;       // 32
  localparam int VT = VA + VFP + VS + VBP;       // 22
  localparam int FT = HT * VT;                   // 704 clocks per frame
  localparam int WS = VA * HT;                   // first window cycle, (0,VA)
  localparam int DL = (VT - 1 - G) * HT + HT - 1;// deadline cycle, (HT-1,VT-1-G)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_done = 1'b0;
  logic        hsync, vsync, video_on, frame_start, upd_req, buf_swap, frame_miss;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] frame_count;
`ifdef VGA_MISS_STATS_EN
  logic [7:0]  missed_frames;
`endif

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  vga_frame_scheduler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .GUARD_LINES(G)
  ) dut (
    .clk25MHz   (clk),
    .rst_n      (rst_n),
    .upd_done   (upd_done),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_start(frame_start),
    .upd_req    (upd_req),
    .buf_swap   (buf_swap),
    .frame_miss (frame_miss),
    .frame_count(frame_count)
`ifdef VGA_MISS_STATS_EN
    ,
    .missed_frames(missed_frames)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: position within the frame plus when (if ever) the
  // renderer answered inside this frame's window.
  // ---------------------------------------------------------------------------
  int pos = 0;
  bit done_seen = 1'b0;
  int done_pos = 0;
  int fc = 0;
  int miss_cnt = 0;

  logic [9:0] exp_h, exp_v;
  logic exp_hs, exp_vs, exp_von, exp_fs, exp_req, exp_swap, exp_miss;

  always_comb begin
    exp_h    = 10'(pos % HT);
    exp_v    = 10'(pos / HT);
    exp_hs   = !((pos % HT) >= HA + HFP && (pos % HT) < HA + HFP + HS);
    exp_vs   = !((pos / HT) >= VA + VFP && (pos / HT) < VA + VFP + VS);
    exp_von  = ((pos % HT) < HA) && ((pos / HT) < VA);
    exp_fs   = (pos == 0);
    exp_req  = (pos >= WS) && (pos <= DL) && !(done_seen && done_pos < pos);
    exp_swap = done_seen && (pos == done_pos + 1);
    exp_miss = !done_seen && (pos == DL + 1);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      pos       <= 0;
      done_seen <= 1'b0;
      fc        <= 0;
      miss_cnt  <= 0;
    end else begin
      if (exp_miss && miss_cnt < 255) miss_cnt <= miss_cnt + 1;
      if (pos == FT - 1) begin
        pos       <= 0;
        done_seen <= 1'b0;
        fc        <= (fc + 1) % 65536;
      end else begin
        pos <= pos + 1;
        if (!done_seen && pos >= WS && pos <= DL && upd_done) begin
          done_seen <= 1'b1;
          done_pos  <= pos;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until the model reaches the given frame position (bounded).
  task automatic goto_pos(input int target);
    int n = 0;
    while (pos != target && n < 2 * FT) begin
      tick();
      n++;
    end
    checks++;
    if (pos != target) begin
      errors++;
      $display("FAIL goto_pos: reached %0d, required %0d", pos, target);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    upd_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({pixel_x, pixel_y, hsync, vsync, video_on, frame_start,
           upd_req, buf_swap, frame_miss, frame_count} !==
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL reset_state: x=%0d y=%0d hs=%b vs=%b von=%b fs=%b req=%b swp=%b mis=%b fc=%0d",
                 pixel_x, pixel_y, hsync, vsync, video_on, frame_start,
                 upd_req, buf_swap, frame_miss, frame_count);
      end
    end
    upd_done = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_raster();
    int hs_low = 0, vs_low = 0, von_low_line0 = 0, fs_cnt = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      checks++;
      if (pixel_x !== exp_h || pixel_y !== exp_v) begin
        errors++;
        $display("FAIL raster_xy: got (%0d,%0d) required (%0d,%0d)", pixel_x, pixel_y, exp_h, exp_v);
      end
      checks++;
      if ({hsync, vsync, video_on, frame_start} !== {exp_hs, exp_vs, exp_von, exp_fs}) begin
        errors++;
        $display("FAIL raster_decode at (%0d,%0d): got %b required %b", exp_h, exp_v,
                 {hsync, vsync, video_on, frame_start}, {exp_hs, exp_vs, exp_von, exp_fs});
      end
      checks++;
      if ({upd_req, buf_swap, frame_miss} !== {exp_req, exp_swap, exp_miss}) begin
        errors++;
        $display("FAIL raster_hs at (%0d,%0d): got %b required %b", exp_h, exp_v,
                 {upd_req, buf_swap, frame_miss}, {exp_req, exp_swap, exp_miss});
      end
      if (i < HT && !hsync) hs_low++;
      if (i < HT && !video_on) von_low_line0++;
      if (i < FT && !vsync) vs_low++;
      if (frame_start) fs_cnt++;
      tick();
    end
    checks++;
    if (hs_low != HS) begin
      errors++;
      $display("FAIL hsync_width: got %0d required %0d", hs_low, HS);
    end
    checks++;
    if (von_low_line0 != HT - HA) begin
      errors++;
      $display("FAIL hblank_width: got %0d required %0d", von_low_line0, HT - HA);
    end
    checks++;
    if (vs_low != VS * HT) begin
      errors++;
      $display("FAIL vsync_width: got %0d required %0d", vs_low, VS * HT);
    end
    checks++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL frame_start_count: got %0d required 2", fs_cnt);
    end
    checks++;
    if (frame_count !== 16'(fc) || fc != 2) begin
      errors++;
      $display("FAIL frame_count_2: got %0d required 2", frame_count);
    end
  endtask

  task automatic test_random_done(input int nframes);
    int per_mille;
    int strobes;
    goto_pos(0);
    for (int f = 0; f < nframes; f++) begin
      case ($urandom_range(0, 2))
        0: per_mille = 0;
        1: per_mille = 3;
        default: per_mille = 40;
      endcase
      strobes = 0;
      for (int i = 0; i < FT; i++) begin
        checks++;
        if ({upd_req, buf_swap, frame_miss} !== {exp_req, exp_swap, exp_miss}) begin
          errors++;
          $display("FAIL random_hs at (%0d,%0d): got %b required %b", exp_h, exp_v,
                   {upd_req, buf_swap, frame_miss}, {exp_req, exp_swap, exp_miss});
        end
        if (buf_swap || frame_miss) strobes++;
        upd_done = ($urandom_range(0, 999) < per_mille);
        tick();
      end
      checks++;
      if (strobes != 1) begin
        errors++;
        $display("FAIL one_strobe_per_frame: got %0d required 1", strobes);
      end
      checks++;
      if (frame_count !== 16'(fc)) begin
        errors++;
        $display("FAIL frame_count: got %0d required %0d", frame_count, fc);
      end
    end
    upd_done = 1'b0;
  endtask

  task automatic test_done_held();
    int swaps = 0;
    goto_pos(0);
    upd_done = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      checks++;
      if ({upd_req, buf_swap, frame_miss} !== {exp_req, exp_swap, exp_miss}) begin
        errors++;
        $display("FAIL held_hs at (%0d,%0d): got %b required %b", exp_h, exp_v,
                 {upd_req, buf_swap, frame_miss}, {exp_req, exp_swap, exp_miss});
      end
      if (buf_swap) begin
        swaps++;
        checks++;
        if (pixel_x !== 10'd1 || pixel_y !== 10'(VA)) begin
          errors++;
          $display("FAIL held_swap_pos: got (%0d,%0d) required (1,%0d)", pixel_x, pixel_y, VA);
        end
      end
      tick();
    end
    upd_done = 1'b0;
    checks++;
    if (swaps != 2) begin
      errors++;
      $display("FAIL held_swap_count: got %0d required 2", swaps);
    end
  endtask

  task automatic test_deadline_and_idle();
    goto_pos(0);
    goto_pos(3 * HT + 5);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    while (pos < DL) begin
      checks++;
      if (buf_swap !== 1'b0 || frame_miss !== 1'b0) begin
        errors++;
        $display("FAIL idle_done_ignored at (%0d,%0d): swp=%b mis=%b required 0 0",
                 exp_h, exp_v, buf_swap, frame_miss);
      end
      tick();
    end
    checks++;
    if (upd_req !== 1'b1) begin
      errors++;
      $display("FAIL deadline_req_open: got %b required 1", upd_req);
    end
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    checks++;
    if ({buf_swap, frame_miss, upd_req} !== 3'b100 || pixel_x !== 10'd0 || pixel_y !== 10'(VT - G)) begin
      errors++;
      $display("FAIL deadline_done: got swp/mis/req=%b at (%0d,%0d) required 100 at (0,%0d)",
               {buf_swap, frame_miss, upd_req}, pixel_x, pixel_y, VT - G);
    end
  endtask

  task automatic test_mid_reset();
    goto_pos((VA + 2) * HT + 10);
    checks++;
    if (upd_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req: got %b required 1", upd_req);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({pixel_x, pixel_y, upd_req, buf_swap, frame_miss, frame_count} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL mid_reset: x=%0d y=%0d req=%b swp=%b mis=%b fc=%0d required all 0",
               pixel_x, pixel_y, upd_req, buf_swap, frame_miss, frame_count);
    end
    for (int i = 0; i < FT + 3; i++) begin
      checks++;
      if ({pixel_x, pixel_y, upd_req, buf_swap, frame_miss} !==
          {exp_h, exp_v, exp_req, exp_swap, exp_miss}) begin
        errors++;
        $display("FAIL post_reset at (%0d,%0d): got x=%0d y=%0d req/swp/mis=%b required %b",
                 exp_h, exp_v, pixel_x, pixel_y, {upd_req, buf_swap, frame_miss},
                 {exp_req, exp_swap, exp_miss});
      end
      tick();
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_frame_count: got %0d required 1", frame_count);
    end
  endtask

`ifdef VGA_MISS_STATS_EN
  task automatic test_miss_stats();
    upd_done = 1'b0;
    for (int i = 0; i < 3 * FT; i++) begin
      checks++;
      if (missed_frames !== 8'(miss_cnt)) begin
        errors++;
        $display("FAIL missed_frames: got %0d required %0d", missed_frames, miss_cnt);
      end
      tick();
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_raster();
    test_random_done(12);
    test_done_held();
    test_deadline_and_idle();
    test_mid_reset();
`ifdef VGA_MISS_STATS_EN
    test_miss_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
